sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 28 ++
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states, grant encoding,
// bus widths and the round-robin pick.
package sram_arb_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   typedef enum logic {
      GNT_CPU,
      GNT_LDR
   } gnt_e;

   // On a tie the port that did not win last time gets the bus.
   function automatic gnt_e rr_pick(input logic cpu_req, input logic ldr_req, input gnt_e last);
      if (cpu_req && ldr_req) begin
         return (last == GNT_CPU) ? GNT_LDR : GNT_CPU;
      end
      return cpu_req ? GNT_CPU : GNT_LDR;
   endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a CPU port and a
// loader port; each transaction is IDLE -> ACCESS (WAIT_CYCLES) -> DONE.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2   // legal range 1..15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_done,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_oe,
   output logic              sram_we,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   gnt_e              gnt_q, gnt_d;
   gnt_e              last_q, last_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
   logic              sram_oe_q, sram_oe_d;
   logic              sram_we_q, sram_we_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
   logic              cpu_done_q, cpu_done_d;
   logic              ldr_done_q, ldr_done_d;
   gnt_e              pick;

   // The SRAM bus registers double as the transaction latch: they are loaded
   // on grant and cleared on leaving ACCESS, so port inputs are ignored after.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      gnt_d        = gnt_q;
      last_d       = last_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      sram_oe_d    = sram_oe_q;
      sram_we_d    = sram_we_q;
      cpu_rdata_d  = cpu_rdata_q;
      ldr_rdata_d  = ldr_rdata_q;
      cpu_done_d   = 1'b0;
      ldr_done_d   = 1'b0;
      pick         = rr_pick(cpu_req, ldr_req, last_q);

      unique case (state_q)
         IDLE: begin
            if (cpu_req || ldr_req) begin
               gnt_d   = pick;
               cnt_d   = '0;
               state_d = ACCESS;
               if (pick == GNT_CPU) begin
                  sram_addr_d  = cpu_addr;
                  sram_wdata_d = cpu_wdata;
                  sram_we_d    = cpu_we;
                  sram_oe_d    = ~cpu_we;
               end else begin
                  sram_addr_d  = ldr_addr;
                  sram_wdata_d = ldr_wdata;
                  sram_we_d    = ldr_we;
                  sram_oe_d    = ~ldr_we;
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d      = DONE;
               sram_addr_d  = '0;
               sram_wdata_d = '0;
               sram_oe_d    = 1'b0;
               sram_we_d    = 1'b0;
               cpu_done_d   = (gnt_q == GNT_CPU);
               ldr_done_d   = (gnt_q == GNT_LDR);
               if (sram_oe_q) begin
                  if (gnt_q == GNT_CPU) cpu_rdata_d = sram_rdata;
                  else                  ldr_rdata_d = sram_rdata;
               end
            end
         end
         DONE: begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: reset is sampled on the clock edge here, and all state uses <= so
   // every flop sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         gnt_q        <= GNT_CPU;
         last_q       <= GNT_LDR;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         sram_oe_q    <= 1'b0;
         sram_we_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         ldr_rdata_q  <= '0;
         cpu_done_q   <= 1'b0;
         ldr_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         last_q       <= last_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         sram_oe_q    <= sram_oe_d;
         sram_we_q    <= sram_we_d;
         cpu_rdata_q  <= cpu_rdata_d;
         ldr_rdata_q  <= ldr_rdata_d;
         cpu_done_q   <= cpu_done_d;
         ldr_done_q   <= ldr_done_d;
      end
   end

   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;
   assign sram_oe    = sram_oe_q;
   assign sram_we    = sram_we_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign ldr_rdata  = ldr_rdata_q;
   assign cpu_done   = cpu_done_q;
   assign ldr_done   = ldr_done_q;
   assign busy       = (state_q != IDLE);

endmodule
